adc_sm_capture: RTL

- Receive-side reader for the stochastic ADC slice output interface: `clk_adder` strobe, `sign_out`, and `adder_out` (sign/magnitude).
- Synchronizes the ADC strobe into the digital clock domain and captures each new code.
- Converts the code to two's complement and buffers it in a small FIFO with a valid/ready output toward the DSP datapath.
- Sits between one ADC slice and the downstream equalizer/deserializer logic.

---
 rtl/adc_capture_pkg.sv | 34 +++
 rtl/adc_sm_capture_if.sv | 22 ++
 rtl/adc_capture_fifo.sv | 70 +++++++
 rtl/adc_sm_capture.sv | 120 ++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// ----------------------------------------------------------------------------
// adc_capture_pkg
// Shared constants and helpers for the stochastic ADC slice capture path.
//   NADC_DEFAULT / DEPTH_DEFAULT / SYNC_STAGES_DEFAULT : default parameters
//   adc_mag_max(nadc) : largest magnitude code, 2^(nadc-1)-1
//   level_w(depth)    : width of a FIFO occupancy count, $clog2(depth)+1
//   level_t           : occupancy type for the default FIFO depth
//   sm_to_tc(s, m)    : sign/magnitude to two's complement (s=1 is positive)
// ----------------------------------------------------------------------------
package adc_capture_pkg;

   localparam int NADC_DEFAULT        = 8;
   localparam int DEPTH_DEFAULT       = 4;
   localparam int SYNC_STAGES_DEFAULT = 2;

   function automatic int adc_mag_max(input int nadc);
      return (1 << (nadc - 1)) - 1;
   endfunction

   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [level_w(DEPTH_DEFAULT)-1:0] level_t;

   // Computed at 32 bits so one function serves every code width; callers
   // keep the low Nadc bits. The magnitude never reaches the sign bit, so
   // the truncated result is always exact.
   function automatic logic signed [31:0] sm_to_tc(input logic        sign,
                                                  input logic [31:0] mag);
      return sign ? $signed(mag) : -$signed(mag);
   endfunction

endpackage

// File: rtl/adc_sm_capture_if.sv
// ----------------------------------------------------------------------------
// adc_sm_capture_if
// Valid/ready sample stream from the ADC capture block toward the DSP path.
//   data  : W-bit two's complement sample (head of FIFO)
//   valid : sample available
//   ready : downstream accepts data
// Modports: master (capture block), slave (downstream consumer).
// ----------------------------------------------------------------------------
interface adc_sm_capture_if
   import adc_capture_pkg::*;
#(
   parameter int W = NADC_DEFAULT
) ();

   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/adc_capture_fifo.sv
// ----------------------------------------------------------------------------
// adc_capture_fifo
// Small synchronous FIFO with a separately tracked occupancy count.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full unless popping the same cycle)
//   pop      : release head entry (ignored when empty)
//   wdata    : W-bit write data
//   rdata    : head entry, combinational; 0 when empty
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module adc_capture_fifo
   import adc_capture_pkg::*;
#(
   parameter int W     = NADC_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              wdata,
   output logic [W-1:0]              rdata,
   output logic                      full,
   output logic                      empty,
   output logic [level_w(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally: DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // NOTE: the storage array has no reset; stale entries are never visible
   // because rdata is forced to 0 whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wptr] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/adc_sm_capture.sv
// ----------------------------------------------------------------------------
// adc_sm_capture
// Receive-side reader for one stochastic ADC slice. Synchronizes the ADC
// strobe into clk, captures each new sign/magnitude code on its rising edge,
// converts it to two's complement and queues it toward the DSP datapath.
//   clk, rst  : system clock (>= 4x clk_adder), synchronous active-high reset
//   clk_adder : ADC strobe, asynchronous; code updates on its rising edge
//   sign_in   : ADC sign, 1 = positive
//   mag_in    : ADC code; only the low Nadc-1 bits carry magnitude
//   en        : capture enable (edges seen while low are lost)
//   clr_ovf   : clears the sticky overflow flag
//   out_if    : master stream (data/valid/ready) of converted samples
//   overflow  : sticky, a capture was dropped because the FIFO was full
//   level     : FIFO occupancy
//   sat_count : [ADC_SAT_COUNT_EN only] saturating count of full-scale
//               captures, cleared by rst and clr_ovf
// Optional feature macro: ADC_SAT_COUNT_EN
// ----------------------------------------------------------------------------
module adc_sm_capture
   import adc_capture_pkg::*;
#(
   parameter int Nadc        = NADC_DEFAULT,
   parameter int DEPTH       = DEPTH_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clk_adder,
   input  logic                      sign_in,
   input  logic [Nadc-1:0]           mag_in,
   input  logic                      en,
   input  logic                      clr_ovf,
   adc_sm_capture_if.master          out_if,
   output logic                      overflow,
   output logic [level_w(DEPTH)-1:0] level
`ifdef ADC_SAT_COUNT_EN
   ,
   output logic [15:0]               sat_count
`endif
);

   localparam logic [Nadc-2:0] ADC_MAG_MAX = (Nadc - 1)'(adc_mag_max(Nadc));

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_last;
   logic                   s_hist;
   logic                   cap_evt;
   logic [Nadc-2:0]        mag;
   logic signed [31:0]     tc_full;
   logic [Nadc-1:0]        tc;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   drop;
   logic                   unused_bits;

   // Synchronizer and edge history preset to 1 so a strobe that is already
   // high when reset releases is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         s_hist <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], clk_adder};
         s_hist <= s_last;
      end
   end

   assign s_last  = sync_q[SYNC_STAGES-1];
   assign cap_evt = en & s_last & ~s_hist;

   // Code is held for a whole strobe period, so it is sampled directly.
   assign mag     = mag_in[Nadc-2:0];
   assign tc_full = sm_to_tc(sign_in, 32'(mag));
   assign tc      = tc_full[Nadc-1:0];

   // Code MSB is not part of the magnitude; upper conversion bits are
   // sign extension only.
   assign unused_bits = ^{mag_in[Nadc-1], tc_full[31:Nadc]};

   assign out_if.valid = ~fifo_empty;
   assign pop          = out_if.valid & out_if.ready;
   assign drop         = cap_evt & fifo_full & ~pop;

   adc_capture_fifo #(
      .W     (Nadc),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap_evt),
      .pop   (pop),
      .wdata (tc),
      .rdata (out_if.data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst)          overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

`ifdef ADC_SAT_COUNT_EN
   logic sat_hit;

   // Counts every full-scale capture, whether it was queued or dropped.
   assign sat_hit = cap_evt & (mag == ADC_MAG_MAX);

   always_ff @(posedge clk) begin
      if (rst)                        sat_count <= '0;
      else if (clr_ovf)               sat_count <= sat_hit ? 16'd1 : 16'd0;
      else if (sat_hit && !(&sat_count)) sat_count <= sat_count + 16'd1;
   end
`endif

endmodule
